tdm_demux_8ch: RTL
==================

# tdm_demux_8ch

Receive-side partner of the 8-to-1 multiplexer blocks. It takes a time-division-multiplexed serial stream, one bit per channel slot, eight slots per frame, with a frame-sync marker on slot 0. It recovers the slot position, redistributes each slot's bit to its own channel output, and presents all eight channels in parallel once per frame. It sits at the far end of a serial link driven by a counter-sequenced 8x1 mux.

## Interface
Parameters:
- MISS_LIMIT, default 2: consecutive missing slot-0 fsync markers tolerated before lock is dropped. Legal range 1..7.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: sample strobe. One slot is consumed per clk edge with en=1.
- din, input, 1: serial TDM data bit.
- fsync, input, 1: frame marker, qualified by en. It is high on the slot-0 bit.
- y, output, 8: registered channel outputs. y[k] is the bit from slot k.
- slot, output, 3: index of the next slot to be sampled.
- frame_valid, output, 1: one-cycle pulse when y is updated.
- locked, output, 1: high while the block is frame-aligned.
- sync_err, output, 1: one-cycle pulse when fsync arrives at a slot other than slot 0.

## Operation
- Reset values: y=0, slot=0, frame_valid=0, sync_err=0, locked=0. Internally: shadow register=0, miss counter=0, state=HUNT.
- With en=0, all state holds. frame_valid and sync_err are 0 on that cycle.
- HUNT state (locked=0):
  - en=1 with fsync=1: write din to shadow[0], set slot=1, miss=0, go to LOCKED.
  - en=1 with fsync=0: discard the bit. slot stays 0.
- LOCKED state (locked=1), on an edge with en=1:
  - Normal sample: write din to shadow[slot], slot = slot+1 mod 8.
  - slot=7 sampled: load y = {din, shadow[6:0]} and pulse frame_valid. slot wraps to 0.
  - slot=0 with fsync=1: normal sample, miss=0.
  - slot=0 with fsync=0, and miss+1 < MISS_LIMIT: flywheel. Sample normally and increment miss.
  - slot=0 with fsync=0, and miss+1 = MISS_LIMIT: drop lock. Go to HUNT, locked=0, discard the bit, slot=0, miss=0. y keeps its last value.
  - slot≠0 with fsync=1: resync. Pulse sync_err. Discard the partial frame, with no y update and no frame_valid. Treat the bit as slot 0: write shadow[0]=din, set slot=1, miss=0. The block stays LOCKED.
- A resync at slot 7 takes priority over frame completion: y is not loaded.
- Shadow bits from a discarded frame are never visible on y. Every slot is rewritten before the next y load.
- rst asserted mid-frame returns all outputs to their reset values immediately, regardless of clk.

## Timing
- y, frame_valid, sync_err, locked and slot are all registered, with no combinational path from the inputs.
- Latency: y and frame_valid change on the same edge that samples slot 7. frame_valid is high for exactly that one following cycle.
- Back-to-back frames with continuous en give a frame_valid pulse every 8 cycles.
- locked rises on the edge that samples the first fsync in HUNT. It falls on the edge that samples the final missed slot-0.
- sync_err is high for the one cycle after the offending edge.

## Test plan
- Reset during slot 4 of a frame: on rst, y=0, slot=0, locked=0 immediately. After release, no frame_valid appears until a new fsync arrives.
- Lock and decode: continuous en, fsync on the first bit, din=0,1,0,1,0,1,0,1. Then y=8'hAA, a single frame_valid pulse on the 8th edge, locked=1 from the 1st edge.
- Gapped en: the same frame with en high on alternate cycles. Then y=8'hAA after the 8th en edge, slot holds during gaps, no extra frame_valid.
- Early fsync: fsync asserted at slot 3 in LOCKED. Then sync_err pulses once, y is unchanged, and the following 8 bits din=1,1,1,1,0,0,0,0 give y=8'h0F.
- Lost sync with MISS_LIMIT=2: frame 1 has fsync, frames 2 and 3 have none.
  - Frame 2 still delivers y with frame_valid (flywheel).
  - At slot 0 of frame 3, locked falls and y holds frame 2's value.
- Back-to-back frames: three frames, fsync on each, patterns 8'h01, 8'h80, 8'hFF. Then frame_valid pulses at edges 8, 16 and 24 with those y values, and there is no sync_err.

Source files
------------

// File: rtl/tdm_demux_8ch_if.sv
// tdm_if: serial TDM input and parallel channel outputs of the 8-channel demux
interface tdm_if;
  logic en;
  logic din;
  logic fsync;
  logic [7:0] y;
  logic [2:0] slot;
  logic frame_valid;
  logic locked;
  logic sync_err;
  modport master (output en, din, fsync, input y, slot, frame_valid, locked, sync_err);
  modport slave (input en, din, fsync, output y, slot, frame_valid, locked, sync_err);
endinterface

// File: rtl/tdm_demux_8ch.sv
// tdm_demux_8ch: frame-aligns an 8-slot TDM bit stream and presents the channels in parallel
module tdm_demux_8ch #(
  parameter int MISS_LIMIT = 2
) (
  input logic clk,
  input logic rst,
  tdm_if.slave bus
);
  typedef enum logic {HUNT, LOCK} state_t;
  localparam logic [2:0] MISS_LAST = 3'(MISS_LIMIT - 1);
  state_t state;
  logic [6:0] shadow;
  logic [2:0] miss;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      shadow <= '0;
      miss <= '0;
      bus.y <= '0;
      bus.slot <= '0;
      bus.frame_valid <= 1'b0;
      bus.locked <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.sync_err <= 1'b0;
      if (bus.en) begin
        if (state == HUNT) begin
          if (bus.fsync) begin
            shadow[0] <= bus.din;
            bus.slot <= 3'd1;
            miss <= '0;
            state <= LOCK;
            bus.locked <= 1'b1;
          end
        end else if (bus.fsync && bus.slot != 3'd0) begin
          bus.sync_err <= 1'b1;
          shadow[0] <= bus.din;
          bus.slot <= 3'd1;
          miss <= '0;
        end else if (!bus.fsync && bus.slot == 3'd0 && miss == MISS_LAST) begin
          state <= HUNT;
          bus.locked <= 1'b0;
          miss <= '0;
        end else begin
          if (bus.slot == 3'd0) miss <= bus.fsync ? 3'd0 : miss + 3'd1;
          if (bus.slot == 3'd7) begin
            bus.y <= {bus.din, shadow};
            bus.frame_valid <= 1'b1;
          end else begin
            shadow[bus.slot] <= bus.din;
          end
          bus.slot <= bus.slot + 3'd1;
        end
      end
    end
  end
endmodule
